// File: rtl/axi_lite_bus_responder.sv
// AXI4-Lite register-bank responder: decodes a NUM_REGS x 32-bit window at BASE_ADDR,
// with independent AW/W holding registers, byte-strobed writes and a registered read path.
module axi_lite_bus_responder #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h6000_0000,
    parameter int unsigned       NUM_REGS  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_W-1:0]     s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_W-1:0]     s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_W-1:0]     s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready
);

    localparam int unsigned       IDX_W      = $clog2(NUM_REGS);
    localparam int unsigned       STRB_W     = DATA_W / 8;
    localparam logic [ADDR_W-1:0] BANK_BYTES = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0]        RESP_OKAY  = 2'b00;
    localparam logic [1:0]        RESP_SLVERR = 2'b10;

    logic [DATA_W-1:0] r_regs [NUM_REGS];

    logic              r_aw_held;
    logic [ADDR_W-1:0] r_awaddr;
    logic              r_w_held;
    logic [DATA_W-1:0] r_wdata;
    logic [STRB_W-1:0] r_wstrb;
    logic              r_bvalid;
    logic [1:0]        r_bresp;
    logic              r_rvalid;
    logic [DATA_W-1:0] r_rdata;
    logic [1:0]        r_rresp;

    logic              w_aw_hs;
    logic              w_w_hs;
    logic              w_ar_hs;
    logic              w_commit;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic [STRB_W-1:0] w_wr_strb;
    logic [ADDR_W-1:0] w_wr_off;
    logic              w_wr_hit;
    logic [IDX_W-1:0]  w_wr_idx;
    logic [ADDR_W-1:0] w_rd_off;
    logic              w_rd_hit;
    logic [IDX_W-1:0]  w_rd_idx;

    // Readies depend only on registered state, never on the incoming valids.
    assign s_awready = !r_aw_held && !r_bvalid;
    assign s_wready  = !r_w_held && !r_bvalid;
    assign s_arready = !r_rvalid;

    assign w_aw_hs = s_awvalid && s_awready;
    assign w_w_hs  = s_wvalid && s_wready;
    assign w_ar_hs = s_arvalid && s_arready;

    assign w_wr_addr = r_aw_held ? r_awaddr : s_awaddr;
    assign w_wr_data = r_w_held ? r_wdata : s_wdata;
    assign w_wr_strb = r_w_held ? r_wstrb : s_wstrb;
    assign w_commit  = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);

    assign w_wr_off = w_wr_addr - BASE_ADDR;
    assign w_wr_hit = w_wr_off < BANK_BYTES;
    assign w_wr_idx = w_wr_off[IDX_W+1:2];

    assign w_rd_off = s_araddr - BASE_ADDR;
    assign w_rd_hit = w_rd_off < BANK_BYTES;
    assign w_rd_idx = w_rd_off[IDX_W+1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_awaddr  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= '0;
        end else begin
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= w_wr_hit ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (w_aw_hs) begin
                    r_aw_held <= 1'b1;
                    r_awaddr  <= s_awaddr;
                end
                if (w_w_hs) begin
                    r_w_held <= 1'b1;
                    r_wdata  <= s_wdata;
                    r_wstrb  <= s_wstrb;
                end
                if (r_bvalid && s_bready) begin
                    r_bvalid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_commit && w_wr_hit) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
                if (w_wr_strb[b]) begin
                    r_regs[w_wr_idx][8*b +: 8] <= w_wr_data[8*b +: 8];
                end
            end
        end
    end

    // Reads sample r_regs before any same-edge write lands, returning the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= '0;
        end else begin
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_hit ? r_regs[w_rd_idx] : '0;
                r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (r_rvalid && s_rready) begin
                r_rvalid <= 1'b0;
            end
        end
    end

    assign s_bvalid = r_bvalid;
    assign s_bresp  = r_bresp;
    assign s_rvalid = r_rvalid;
    assign s_rdata  = r_rdata;
    assign s_rresp  = r_rresp;

endmodule

// File: tb/tb_axi_lite_bus_responder.sv
// Bench for axi_lite_bus_responder: directed and randomized AXI-Lite traffic against a word-array model.
module tb_axi_lite_bus_responder;

    localparam logic [31:0] BASE = 32'h6000_0000;
    localparam int          NREG = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [NREG];

    axi_lite_bus_responder #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .BASE_ADDR (BASE),
        .NUM_REGS  (NREG)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit in_range(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return off < 32'(NREG * 4);
    endfunction

    function automatic int reg_index(input logic [31:0] addr);
        logic [31:0] off;
        off = addr - BASE;
        return int'(off / 4);
    endfunction

    function automatic logic [1:0] exp_resp(input logic [31:0] addr);
        return in_range(addr) ? 2'b00 : 2'b10;
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int idx;
        if (in_range(addr)) begin
            idx = reg_index(addr);
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
        end
    endtask

    function automatic logic [31:0] model_read(input logic [31:0] addr);
        return in_range(addr) ? model[reg_index(addr)] : 32'h0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 with the B response retired.
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int aw_dly, input int w_dly, input int b_dly);
        bit aw_done = 0;
        bit w_done = 0;
        bit aw_hs;
        bit w_hs;
        int cyc = 0;
        while (!(aw_done && w_done) && cyc < 50) begin
            s_awaddr  = addr;
            s_wdata   = data;
            s_wstrb   = strb;
            s_awvalid = !aw_done && (cyc >= aw_dly);
            s_wvalid  = !w_done && (cyc >= w_dly);
            chk("awready_pending", 32'(s_awready), 32'(!aw_done));
            chk("wready_pending", 32'(s_wready), 32'(!w_done));
            chk("bvalid_before_commit", 32'(s_bvalid), 32'd0);
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            cyc++;
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            chk("write_handshake_timeout", 32'd0, 32'd1);
            return;
        end
        model_write(addr, data, strb);
        chk("bvalid_after_commit", 32'(s_bvalid), 32'd1);
        chk("bresp", 32'(s_bresp), 32'(exp_resp(addr)));
        for (int i = 0; i < b_dly; i++) begin
            tick();
            chk("bvalid_hold", 32'(s_bvalid), 32'd1);
            chk("bresp_hold", 32'(s_bresp), 32'(exp_resp(addr)));
            chk("awready_while_b", 32'(s_awready), 32'd0);
            chk("wready_while_b", 32'(s_wready), 32'd0);
        end
        s_bready = 1'b1;
        tick();
        s_bready = 1'b0;
        chk("bvalid_retired", 32'(s_bvalid), 32'd0);
        chk("awready_after_b", 32'(s_awready), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input int r_dly);
        logic [31:0] exp_data;
        exp_data  = model_read(addr);
        s_araddr  = addr;
        s_arvalid = 1'b1;
        chk("arready_idle", 32'(s_arready), 32'd1);
        tick();
        s_arvalid = 1'b0;
        chk("rvalid", 32'(s_rvalid), 32'd1);
        chk("rdata", s_rdata, exp_data);
        chk("rresp", 32'(s_rresp), 32'(exp_resp(addr)));
        for (int i = 0; i < r_dly; i++) begin
            tick();
            chk("rvalid_hold", 32'(s_rvalid), 32'd1);
            chk("rdata_hold", s_rdata, exp_data);
            chk("rresp_hold", 32'(s_rresp), 32'(exp_resp(addr)));
            chk("arready_while_r", 32'(s_arready), 32'd0);
        end
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        chk("rvalid_retired", 32'(s_rvalid), 32'd0);
        chk("arready_after_r", 32'(s_arready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int sel;

        for (int i = 0; i < NREG; i++) model[i] = '0;

        // Reset state, with readies high during reset
        #2;
        chk("rst_awready", 32'(s_awready), 32'd1);
        chk("rst_wready", 32'(s_wready), 32'd1);
        chk("rst_arready", 32'(s_arready), 32'd1);
        chk("rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("rst_rvalid", 32'(s_rvalid), 32'd0);
        chk("rst_rdata", s_rdata, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Full-word write then readback
        do_write(32'h6000_0008, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
        do_read(32'h6000_0008, 0);

        // Partial strobe
        do_write(32'h6000_0008, 32'h1122_3344, 4'b0101, 0, 0, 0);
        s_araddr = 32'h6000_0008;
        s_arvalid = 1'b1;
        tick();
        s_arvalid = 1'b0;
        chk("partial_strobe_const", s_rdata, 32'hDE22_BE44);
        s_rready = 1'b1;
        tick();
        s_rready = 1'b0;
        do_read(32'h6000_0008, 0);

        // W three cycles before AW, then AW three cycles before W
        do_write(32'h6000_0014, 32'hCAFE_F00D, 4'hF, 3, 0, 0);
        do_read(32'h6000_0014, 0);
        do_write(32'h6000_0018, 32'h0BAD_C0DE, 4'hF, 0, 3, 0);
        do_read(32'h6000_001B, 0);

        // Out-of-range accesses leave the bank untouched
        do_write(32'h6000_0040, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        do_read(32'h5FFF_FFFC, 0);
        for (int i = 0; i < NREG; i++) do_read(BASE + 32'(4 * i), 0);

        // Back-pressure on both response channels
        do_write(32'h6000_0020, 32'h1357_9BDF, 4'hF, 0, 0, 5);
        do_read(32'h6000_0020, 5);

        // Same-edge read and write to register 3
        s_awaddr  = 32'h6000_000C;
        s_wdata   = 32'hA5A5_A5A5;
        s_wstrb   = 4'hF;
        s_araddr  = 32'h6000_000C;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_arvalid = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        chk("same_edge_rvalid", 32'(s_rvalid), 32'd1);
        chk("same_edge_old_data", s_rdata, model[3]);
        chk("same_edge_bvalid", 32'(s_bvalid), 32'd1);
        model_write(32'h6000_000C, 32'hA5A5_A5A5, 4'hF);
        s_bready = 1'b1;
        s_rready = 1'b1;
        tick();
        s_bready = 1'b0;
        s_rready = 1'b0;
        do_read(32'h6000_000C, 0);

        // Randomized mix of reads and writes
        for (int it = 0; it < 60; it++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      a = BASE + 32'(NREG * 4) + $urandom_range(0, 1023);
            else if (sel == 1) a = BASE - 4 * $urandom_range(1, 8);
            else               a = BASE + $urandom_range(0, NREG * 4 - 1);
            d = $urandom;
            if ($urandom_range(0, 1) == 0)
                do_write(a, d, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
            else
                do_read(a, int'($urandom_range(0, 2)));
        end

        // Reset pulse while B is pending
        s_awaddr  = 32'h6000_0004;
        s_wdata   = 32'h7777_8888;
        s_wstrb   = 4'hF;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        tick();
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        chk("pending_bvalid", 32'(s_bvalid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_bvalid", 32'(s_bvalid), 32'd0);
        chk("async_rst_awready", 32'(s_awready), 32'd1);
        chk("async_rst_wready", 32'(s_wready), 32'd1);
        chk("async_rst_arready", 32'(s_arready), 32'd1);
        for (int i = 0; i < NREG; i++) model[i] = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_bvalid", 32'(s_bvalid), 32'd0);
        for (int i = 0; i < NREG; i++) do_read(BASE + 32'(4 * i), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/axi_lite_bus_responder.md
# axi_lite_bus_responder

AXI4-Lite responder (slave) for the core's peripheral bus: it answers the requests the core issues as bus initiator when `BUS_TYPE = AXI_BUS`. It decodes the bus address window starting at 0x6000_0000 and backs it with a bank of 32-bit read/write registers. Each word has byte-lane write strobes. It serves as the standard bus-side endpoint for simulation and for memory-mapped control registers.

## Interface
- `ADDR_W`, 32: address width; matches `C_M_AXI_ADDR_WIDTH`.
- `DATA_W`, 32: data width; fixed at 32, matches `C_M_AXI_DATA_WIDTH`.
- `BASE_ADDR`, 32'h6000_0000: first byte address of the register bank; equals `BUS_ADDR_L`.
- `NUM_REGS`, 16: number of 32-bit registers; power of 2, 2..256.
- `clk`  in  1  clock
- `rst_n`  in  1  asynchronous active-low reset
- `s_awaddr`  in  ADDR_W  write address
- `s_awvalid`  in  1 / `s_awready`  out  1  write address handshake
- `s_wdata`  in  32  write data
- `s_wstrb`  in  4  byte enables
- `s_wvalid`  in  1 / `s_wready`  out  1  write data handshake
- `s_bresp`  out  2  write response
- `s_bvalid`  out  1 / `s_bready`  in  1  write response handshake
- `s_araddr`  in  ADDR_W  read address
- `s_arvalid`  in  1 / `s_arready`  out  1  read address handshake
- `s_rdata`  out  32  read data
- `s_rresp`  out  2  read response
- `s_rvalid`  out  1 / `s_rready`  in  1  read data handshake

## Operation
- **Decode**
  - `off = addr - BASE_ADDR`, computed modulo 2^ADDR_W.
  - The access is in range when `off < NUM_REGS*4`.
  - Register index is `off[$clog2(NUM_REGS)+1:2]`. `addr[1:0]` is ignored.
- **Responses**
  - In range: OKAY (2'b00).
  - Out of range: SLVERR (2'b10). The write is dropped; read returns `s_rdata` = 0.
- **Write path**
  - AW and W are accepted independently and each is captured in its own holding register (aw_held, w_held).
  - `s_awready = !aw_held && !s_bvalid`.
  - `s_wready = !w_held && !s_bvalid`.
  - When both the address and the data are available, from the holding registers or from a handshake in the current cycle, the register is updated at that edge for each byte `i` with `s_wstrb[i]` set. Both holding registers clear and `s_bvalid` sets.
  - `s_bvalid` holds, with `s_bresp` stable, until `s_bready`. At most one write is outstanding.
- **Read path**
  - `s_arready = !s_rvalid`.
  - On AR handshake, `s_rdata`/`s_rresp` are registered and `s_rvalid` sets.
  - Outputs hold stable until `s_rready`. At most one read is outstanding.
- **Read/write channels** are fully independent.
  - If a read and a write to the same register commit at the same edge, the read returns the pre-write value.
- **Registers** reset to 0. There are no side effects on read.
- **Reset (`rst_n` low, any time)**
  - Clears all registers, holding state, `s_bvalid`, `s_rvalid`, `s_bresp`, `s_rresp` and `s_rdata` to 0, asynchronously.
  - In-flight transactions are discarded and no response is produced.
  - Ready outputs are combinational from cleared state, so all three readies read 1 during and after reset.

## Timing
- Write with AW and W in the same cycle (edge N):
  - Register updated at edge N.
  - `s_bvalid` = 1 in cycle N+1.
  - With `s_bready` held high, the next AW/W can be accepted in cycle N+2.
  - Sustained throughput is 1 write per 2 cycles.
- W before AW (or AW before W): the write commits at the edge of the second handshake and B follows one cycle later. While one channel is held, its ready is 0.
- Read (AR handshake at edge N): `s_rvalid` = 1 in cycle N+1. With `s_rready` high, `s_arready` = 1 again in cycle N+2.
- Back-pressure: `s_bvalid`/`s_rvalid` never drop without the matching ready. Response data never changes while valid and not ready.
- No combinational path from any input valid to any output ready.

## Test plan
- Reset, then:
  - write 0xDEAD_BEEF to 0x6000_0008 with strobe 4'hF, AW and W in the same cycle → `s_bvalid` one cycle later with `s_bresp` = 0.
  - Read 0x6000_0008 → `s_rdata` = 0xDEAD_BEEF, `s_rresp` = 0, one cycle after AR.
- Partial strobe:
  - write 0x1122_3344 with strobe 4'b0101 to a register holding 0xDEAD_BEEF → readback 0xDE22_BE44.
- W presented 3 cycles before AW → `s_wready` low after the W handshake. The write commits on the AW handshake and `s_bvalid` follows one cycle later.
- Out-of-range accesses:
  - write to 0x6000_0040 with NUM_REGS = 16 → `s_bresp` = 2'b10 and no register changes.
  - Read 0x5FFF_FFFC → `s_rresp` = 2'b10, `s_rdata` = 0.
- `s_bready`/`s_rready` held low 5 cycles → valid and response held stable. `s_awready`/`s_wready`/`s_arready` stay 0 until release.
- Same-edge read and write to register 3 (old 0x0, new 0xA5A5_A5A5) → read returns 0x0 and a later read returns 0xA5A5_A5A5.
- `rst_n` pulsed low while `s_bvalid` is pending → `s_bvalid` = 0 immediately and all registers read 0 afterward.
